// File: rtl/hls_mac_pkg.sv
// hls_mac_pkg: width helpers, saturation bounds and overflow mode encodings for hls_mac_pipe.
package hls_mac_pkg;
  typedef enum logic {WRAP = 1'b0, SAT = 1'b1} ovf_mode_e;

  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w + 1;
  endfunction

  function automatic int acc_w(input int a_w, input int b_w, input int guard);
    return prod_w(a_w, b_w) + guard;
  endfunction

  function automatic longint sat_max(input int p_w);
    return (longint'(1) <<< (p_w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int p_w);
    return -(longint'(1) <<< (p_w - 1));
  endfunction
endpackage

// File: rtl/hls_mac_fmt.sv
// hls_mac_fmt: narrows a signed accumulator value to P_WIDTH by wrapping or saturating, flagging lost range.
module hls_mac_fmt
  import hls_mac_pkg::*;
#(
  parameter int ACC_W    = 26,
  parameter int P_WIDTH  = 12,
  parameter int SATURATE = 0
) (
  input  logic signed [ACC_W-1:0]   acc_i,
  output logic        [P_WIDTH-1:0] p_o,
  output logic                      ovf_o
);
  localparam logic [P_WIDTH-1:0] P_MAX = P_WIDTH'(sat_max(P_WIDTH));
  localparam logic [P_WIDTH-1:0] P_MIN = P_WIDTH'(sat_min(P_WIDTH));

  logic signed [P_WIDTH-1:0] lo;
  logic fits;

  // The value is representable exactly when re-extending its low bits reproduces it.
  assign lo    = acc_i[P_WIDTH-1:0];
  assign fits  = ACC_W'(lo) == acc_i;
  assign ovf_o = !fits;
  assign p_o   = (SATURATE == int'(SAT) && !fits) ? (acc_i[ACC_W-1] ? P_MIN : P_MAX) : lo;
endmodule

// File: rtl/hls_mac_pipe.sv
// hls_mac_pipe: pipelined multiply / multiply-accumulate with valid/ready flow control and a global stall.
module hls_mac_pipe
  import hls_mac_pkg::*;
#(
  parameter int A_WIDTH   = 12,
  parameter int B_WIDTH   = 5,
  parameter int P_WIDTH   = 12,
  parameter int A_SIGNED  = 1,
  parameter int B_SIGNED  = 0,
  parameter int NUM_STAGE = 4,
  parameter int SATURATE  = 0,
  parameter int ACC_GUARD = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] in_a,
  input  logic [B_WIDTH-1:0] in_b,
  input  logic               in_acc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] out_p,
  output logic               out_ovf
);
  localparam int PROD_W = prod_w(A_WIDTH, B_WIDTH);
  localparam int ACC_W  = acc_w(A_WIDTH, B_WIDTH, ACC_GUARD);
  localparam int ND     = NUM_STAGE - 3;

  logic                      adv;
  logic                      v1_q, acc1_q;
  logic [A_WIDTH-1:0]        a1_q;
  logic [B_WIDTH-1:0]        b1_q;
  logic signed [PROD_W-1:0]  ax, bx, prod_d;
  logic                      v_q [0:ND];
  logic                      f_q [0:ND];
  logic signed [PROD_W-1:0]  p_q [0:ND];
  logic signed [ACC_W-1:0]   acc_q, acc_d, acc_base, prod_x;
  logic [P_WIDTH-1:0]        fmt_p;
  logic                      fmt_ovf;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      v1_q   <= 1'b0;
      acc1_q <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
    end else if (adv) begin
      v1_q   <= in_valid;
      acc1_q <= in_acc;
      a1_q   <= in_a;
      b1_q   <= in_b;
    end

  assign ax     = {{(PROD_W-A_WIDTH){(A_SIGNED != 0) && a1_q[A_WIDTH-1]}}, a1_q};
  assign bx     = {{(PROD_W-B_WIDTH){(B_SIGNED != 0) && b1_q[B_WIDTH-1]}}, b1_q};
  assign prod_d = ax * bx;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      v_q[0] <= 1'b0;
      f_q[0] <= 1'b0;
      p_q[0] <= '0;
    end else if (adv) begin
      v_q[0] <= v1_q;
      f_q[0] <= acc1_q;
      p_q[0] <= prod_d;
    end

  for (genvar i = 1; i <= ND; i++) begin : g_dly
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        v_q[i] <= 1'b0;
        f_q[i] <= 1'b0;
        p_q[i] <= '0;
      end else if (adv) begin
        v_q[i] <= v_q[i-1];
        f_q[i] <= f_q[i-1];
        p_q[i] <= p_q[i-1];
      end
  end

  assign prod_x   = ACC_W'(p_q[ND]);
  assign acc_base = f_q[ND] ? acc_q : '0;
  assign acc_d    = acc_base + prod_x;

  hls_mac_fmt #(
    .ACC_W    (ACC_W),
    .P_WIDTH  (P_WIDTH),
    .SATURATE (SATURATE)
  ) u_fmt (
    .acc_i (acc_d),
    .p_o   (fmt_p),
    .ovf_o (fmt_ovf)
  );

  // Bubbles reaching the last stage clear out_valid but leave acc_q and the held result untouched.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_ovf   <= 1'b0;
      acc_q     <= '0;
    end else if (adv) begin
      out_valid <= v_q[ND];
      if (v_q[ND]) begin
        acc_q   <= acc_d;
        out_p   <= fmt_p;
        out_ovf <= fmt_ovf;
      end
    end
endmodule

// File: tb/tb_hls_mac_pipe.sv
// tb_hls_mac_pipe: wrap and saturate instances driven together, scored against an arithmetic reference model.
module tb_hls_mac_pipe;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_acc = 1'b0, out_ready = 1'b1;
  logic [11:0] in_a = '0;
  logic [4:0]  in_b = '0;
  logic        in_ready, out_valid, out_ovf;
  logic [11:0] out_p;
  logic        rdy_s, val_s, ovf_s;
  logic [11:0] p_s;

  typedef struct { logic [11:0] p; logic o; logic [11:0] sp; logic so; } exp_t;
  typedef struct { logic [11:0] p; logic o; logic [11:0] sp; logic so; int cyc; } rec_t;
  exp_t   exp_q[$];
  rec_t   got[$];
  longint acc_m = 0;
  int     n_chk = 0, n_err = 0, cyc = 0;
  bit     held_v = 0, rnd_done = 0;
  logic [11:0] held_p, held_sp;

  hls_mac_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_acc(in_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_ovf(out_ovf)
  );

  hls_mac_pipe #(.SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_s),
    .in_a(in_a), .in_b(in_b), .in_acc(in_acc),
    .out_valid(val_s), .out_ready(out_ready), .out_p(p_s), .out_ovf(ovf_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input longint got_v, input longint exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got_v, exp_v, cyc);
    end
  endtask

  function automatic longint sext26(input longint x);
    longint y;
    y = x & ((longint'(1) << 26) - 1);
    return (y >= (longint'(1) << 25)) ? y - (longint'(1) << 26) : y;
  endfunction

  // Reference: signed 12-bit a times unsigned 5-bit b, 26-bit accumulator, then 12-bit wrap or clamp.
  function automatic void model(input logic [11:0] a, input logic [4:0] b, input logic f);
    exp_t   e;
    longint prod;
    bit     big;
    prod  = longint'($signed(a)) * longint'(b);
    acc_m = sext26((f ? acc_m : 0) + prod);
    big   = acc_m > 2047 || acc_m < -2048;
    e.p   = 12'(acc_m);
    e.o   = big;
    e.sp  = big ? (acc_m < 0 ? 12'h800 : 12'h7FF) : 12'(acc_m);
    e.so  = big;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (!reset) held_v = 0;
    else begin
      if (held_v) begin
        check("stall_p", out_p, held_p);
        check("stall_sat_p", p_s, held_sp);
        check("stall_valid", out_valid, 1);
      end
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        check("sat_valid", val_s, 1);
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_p", out_p, e.p);
          check("out_ovf", out_ovf, e.o);
          check("sat_p", p_s, e.sp);
          check("sat_ovf", ovf_s, e.so);
        end
        got.push_back('{out_p, out_ovf, p_s, ovf_s, cyc});
      end
      if (in_valid && in_ready) model(in_a, in_b, in_acc);
      held_v  = out_valid && !out_ready;
      held_p  = out_p;
      held_sp = p_s;
    end
  end

  task automatic op(input int a, input int b, input bit f);
    bit ok = 0;
    in_valid = 1; in_a = 12'(a); in_b = 5'(b); in_acc = f;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #13;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_out_ovf", out_ovf, 0);
    @(posedge clk); #1 reset = 1;

    op(-7, 3, 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check("lat_early", out_valid, 0);
    end
    @(posedge clk); #1;
    check("lat_valid", out_valid, 1);
    check("lat_p", out_p, 12'hFEB);
    check("lat_ovf", out_ovf, 0);
    drain();

    got.delete();
    op(2047, 31, 0); op(-2048, 31, 0); op(-7, 3, 0);
    drain();
    check("ovf_count", got.size(), 3);
    if (got.size() == 3) begin
      check("wrap_hi_p", got[0].p, 12'h7E1);  check("wrap_hi_o", got[0].o, 1);
      check("wrap_lo_p", got[1].p, 12'h800);  check("wrap_lo_o", got[1].o, 1);
      check("sat_hi_p", got[0].sp, 12'h7FF);  check("sat_hi_o", got[0].so, 1);
      check("sat_lo_p", got[1].sp, 12'h800);  check("sat_lo_o", got[1].so, 1);
      check("sat_mid_p", got[2].sp, 12'hFEB); check("sat_mid_o", got[2].so, 0);
    end

    got.delete();
    op(3, 4, 0); op(5, 2, 1); op(-1, 10, 1); op(2, 2, 0);
    drain();
    check("stream_count", got.size(), 4);
    if (got.size() == 4) begin
      check("stream_0", got[0].p, 12); check("stream_1", got[1].p, 22);
      check("stream_2", got[2].p, 12); check("stream_3", got[3].p, 4);
      for (int i = 1; i < 4; i++) check("stream_gap", got[i].cyc - got[i-1].cyc, 1);
    end

    got.delete();
    fork
      for (int i = 0; i < 8; i++) op(i + 1, i + 2, i != 0);
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    check("stall_count", got.size(), 8);

    got.delete();
    op(3, 4, 0); op(5, 2, 1);
    drain();
    if (got.size() == 2) check("pre_rst_sum", got[1].p, 22);
    else check("pre_rst_count", got.size(), 2);
    op(1, 2, 1); op(1, 3, 1); op(2, 2, 1);
    @(posedge clk); #2;
    reset = 0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_p", out_p, 0);
    check("arst_sat_p", p_s, 0);
    check("arst_in_ready", in_ready, 1);
    exp_q.delete();
    acc_m = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    got.delete();
    op(1, 1, 1);
    drain();
    check("post_rst_count", got.size(), 1);
    if (got.size() == 1) check("post_rst_p", got[0].p, 1);

    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          else if ($urandom_range(0, 3) == 0)
            op($urandom_range(0, 1) ? 2047 : -2048, $urandom_range(0, 31), 1'($urandom_range(0, 1)));
          else
            op(int'($urandom_range(0, 4095)), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end
        rnd_done = 1;
      end
      while (!rnd_done) begin
        @(posedge clk); #1;
        out_ready = $urandom_range(0, 2) != 0;
      end
    join
    out_ready = 1;
    drain();
    check("final_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
